mult_control_unit: RTL

//  Sequencing stage for the 8x8 signed add-shift multiplier.
//  - Holds the X (sign), A (upper product) and B (multiplier/lower product) registers, and latches multiplicand S.
//  - Drives the 9-bit adder's S, A, select_op and M inputs and captures its sum.
//  - Runs 8 add/shift iterations; the 8th add is a subtract (two's-complement multiplier MSB).

---
 rtl/mult_control_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_control_unit.sv
// ============================================================================
// mult_control_unit
// ----------------------------------------------------------------------------
// Sequencing stage for a WIDTH x WIDTH signed add-shift multiplier.
//
// The block owns the X (sign extension), A (upper product) and B
// (multiplier / lower product) registers and latches the multiplicand S.
// It drives an external, purely combinational (WIDTH+1)-bit adder
// (operands {X,A} and {S[msb],S}, with select_op choosing subtract and M
// gating the addend) and captures the sum in the same cycle.
//
// Sequence:  IDLE -> START -> {ADD -> SHIFT} x WIDTH -> HOLD -> IDLE
// The last ADD is a subtract, because the multiplier MSB carries
// negative weight in two's complement.
//
// Optional build macro:
//   MULT_CTRL_ADD_SKIP_EN  when defined, an ADD whose M bit would be 0 is
//                          skipped (START/SHIFT go straight to SHIFT).
//                          Final register values are the same either way;
//                          only the latency changes.
//
// Ports:
//   Clk            in   1      rising-edge clock
//   Reset_n        in   1      asynchronous active-low reset
//   Run            in   1      level start request (sampled in IDLE)
//   ClearA_LoadB   in   1      in IDLE: B<=Din, A<=0, X<=0 (wins over Run)
//   Din            in   WIDTH  multiplicand (START) / multiplier (load)
//   Final_Sum      in   WIDTH  adder sum, low bits
//   Final_Sum_9th  in   1      adder sum, top bit
//   add_S          out  WIDTH  S register to the adder
//   add_S_9th      out  1      sign extension of S
//   add_A          out  WIDTH  A register to the adder
//   add_A_9th      out  1      X register to the adder
//   select_op      out  1      1 = subtract (final ADD only)
//   M              out  1      current multiplier bit, B[0]
//   Aval, Bval     out  WIDTH  product high / low halves
//   Xval           out  1      product sign
//   Busy           out  1      high in START/ADD/SHIFT
//   Done           out  1      high in HOLD
// ============================================================================
module mult_control_unit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Din,
    input  logic [WIDTH-1:0] Final_Sum,
    input  logic             Final_Sum_9th,
    output logic [WIDTH-1:0] add_S,
    output logic             add_S_9th,
    output logic [WIDTH-1:0] add_A,
    output logic             add_A_9th,
    output logic             select_op,
    output logic             M,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef MULT_CTRL_ADD_SKIP_EN
    localparam bit ADD_SKIP = 1'b1;
`else
    localparam bit ADD_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Status outputs are registered from the next-state decode so they
    // change exactly on the state transition and never glitch.
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic sel_q,  sel_d;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no
        // path through the case statement can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        x_d     = x_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (ClearA_LoadB) begin
                    b_d = Din;
                    a_d = '0;
                    x_d = 1'b0;
                end else if (Run) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // B is kept, so back-to-back runs multiply the previous
                // low product half.
                s_d   = Din;
                a_d   = '0;
                x_d   = 1'b0;
                cnt_d = '0;
                state_d = (ADD_SKIP && !b_q[0]) ? S_SHIFT : S_ADD;
            end

            S_ADD: begin
                // Captured unconditionally: with M=0 the adder passes
                // {X,A} straight through.
                a_d     = Final_Sum;
                x_d     = Final_Sum_9th;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                // Arithmetic right shift of the {X,A,B} chain; X keeps the
                // sign so it is left unchanged.
                a_d   = {x_q, a_q[WIDTH-1:1]};
                b_d   = {a_q[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_HOLD;
                end else if (ADD_SKIP && !b_d[0]) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_ADD;
                end
            end

            S_HOLD: begin
                // Waiting for Run to drop makes a held Run produce one
                // multiplication only.
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_START) || (state_d == S_ADD) || (state_d == S_SHIFT);
        done_d = (state_d == S_HOLD);
        // cnt_d is the count that will be current during the next ADD.
        sel_d  = (state_d == S_ADD) && (cnt_d == LAST_BIT);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign add_S     = s_q;
    assign add_S_9th = s_q[WIDTH-1];
    assign add_A     = a_q;
    assign add_A_9th = x_q;
    assign select_op = sel_q;
    assign M         = b_q[0];
    assign Aval      = a_q;
    assign Bval      = b_q;
    assign Xval      = x_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule
